// File: rtl/olimp_vec_macc.sv
// olimp_vec_macc: multi-lane int8 vector multiply-accumulate with grouped results.
// Pipeline stages:
//   S1 registers the per-element products.
//   S2 registers the per-lane sums.
//   S3 accumulates each sum and presents the result when the group ends.
// Define OLIMP_VEC_MACC_SAT_EN for saturating accumulators with sticky
// per-lane flags. Without it, the accumulators wrap and out_sat reads 0.
module olimp_vec_macc #(
  parameter int LANES       = 2,
  parameter int ELEMS       = 8,
  parameter int ACC_W       = 32,
  parameter int DATA_SIGNED = 0,
  parameter int CNT_W       = 16
) (
  input  logic                     clk_dsp,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [ELEMS*8-1:0]       data,
  input  logic [LANES*ELEMS*8-1:0] coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   acc,
  output logic [CNT_W-1:0]         out_beats,
  output logic [LANES-1:0]         out_sat
);

  localparam int SUM_W = 17 + $clog2(ELEMS);
  localparam int NP    = LANES * ELEMS;

  logic                    stall;
  logic                    s1_valid, s1_last, s2_valid, s2_last, first_q;
  logic signed [16:0]      d_ext, c_ext;
  logic signed [16:0]      prod_d [NP];
  logic signed [16:0]      prod_q [NP];
  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] sum_d [LANES];
  logic signed [SUM_W-1:0] sum_q [LANES];
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_d [LANES];
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] acc_o_q [LANES];
  logic [LANES-1:0]        sat_d;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
`ifdef OLIMP_VEC_MACC_SAT_EN
  logic [LANES-1:0]        sat_q;
  logic signed [ACC_W:0]   wide;
`endif

  // A result waiting for a consumer freezes the whole pipeline.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Products: data is zero- or sign-extended; the coefficients are always signed.
  // Every product fits in 17 bits.
  always_comb begin
    d_ext = '0;
    c_ext = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int e = 0; e < ELEMS; e++) begin
        d_ext = {{9{(DATA_SIGNED != 0) & data[e*8+7]}}, data[e*8 +: 8]};
        c_ext = {{9{coef[(l*ELEMS+e)*8+7]}}, coef[(l*ELEMS+e)*8 +: 8]};
        prod_d[l*ELEMS+e] = d_ext * c_ext;
      end
    end
  end

  // Sum each lane's registered products.
  always_comb begin
    sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_s = '0;
      for (int e = 0; e < ELEMS; e++) begin
        sum_s = sum_s + SUM_W'(prod_q[l*ELEMS+e]);
      end
      sum_d[l] = sum_s;
    end
  end

  // Next accumulator value: a new group starts from zero.
  always_comb begin
    base  = '0;
    sat_d = '0;
`ifdef OLIMP_VEC_MACC_SAT_EN
    wide  = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      base = first_q ? '0 : acc_q[l];
`ifdef OLIMP_VEC_MACC_SAT_EN
      wide = (ACC_W+1)'(base) + (ACC_W+1)'(sum_q[l]);
      if (wide[ACC_W] != wide[ACC_W-1]) begin
        acc_d[l] = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        sat_d[l] = 1'b1;
      end else begin
        acc_d[l] = wide[ACC_W-1:0];
        sat_d[l] = first_q ? 1'b0 : sat_q[l];
      end
`else
      acc_d[l] = base + ACC_W'(sum_q[l]);
`endif
    end
    cnt_d = first_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
  end

  // Registers for S1 (products) and S2 (sums), each with its valid and last bits.
  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      for (int i = 0; i < NP; i++) prod_q[i] <= '0;
      for (int l = 0; l < LANES; l++) sum_q[l] <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      prod_q   <= prod_d;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      sum_q    <= sum_d;
    end
  end

  // S3: accumulate. At the end of a group, load the result registers.
  // With no stall, any held result has already been consumed.
  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      first_q   <= 1'b1;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_beats <= '0;
      out_sat   <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l]   <= '0;
        acc_o_q[l] <= '0;
      end
`ifdef OLIMP_VEC_MACC_SAT_EN
      sat_q <= '0;
`endif
    end else if (!stall) begin
      out_valid <= s2_valid & s2_last;
      if (s2_valid) begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        first_q <= s2_last;
`ifdef OLIMP_VEC_MACC_SAT_EN
        sat_q   <= sat_d;
`endif
        if (s2_last) begin
          acc_o_q   <= acc_d;
          out_beats <= cnt_d;
          out_sat   <= sat_d;
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_acc
    assign acc[g*ACC_W +: ACC_W] = acc_o_q[g];
  end

endmodule
